// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter that shares one register-slave bus between NUM_MST requesters.
// One transaction is in flight at a time and every output comes straight from a flop.
module reg_bus_arbiter #(
  parameter int NUM_MST    = 2,
  parameter int ADDR_WIDTH = 24
) (
  input  logic                          reg_clk,
  input  logic                          reg_rst,
  input  logic [NUM_MST-1:0]            m_req,
  input  logic [NUM_MST-1:0]            m_wr,
  input  logic [NUM_MST*ADDR_WIDTH-1:0] m_addr,
  input  logic [NUM_MST*4-1:0]          m_we,
  input  logic [NUM_MST*32-1:0]         m_wdat,
  output logic [NUM_MST-1:0]            m_ack,
  output logic [31:0]                   m_rdat,
  output logic                          busy,
  output logic                          reg_wr,
  output logic                          reg_rd,
  output logic [3:0]                    reg_we,
  output logic [ADDR_WIDTH-1:0]         reg_addr,
  output logic [31:0]                   reg_wdat,
  input  logic [31:0]                   reg_rdat
);

  localparam int IDX_W = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RDWAIT = 2'd2,
    DONE   = 2'd3
  } state_e;

  state_e                  state_q;
  logic [IDX_W-1:0]        last_gnt_q;
  logic                    wr_q;
  logic [NUM_MST-1:0]      m_ack_q;
  logic [31:0]             m_rdat_q;
  logic                    busy_q;
  logic                    reg_wr_q;
  logic                    reg_rd_q;
  logic [3:0]              reg_we_q;
  logic [ADDR_WIDTH-1:0]   reg_addr_q;
  logic [31:0]             reg_wdat_q;

  logic                    any_req_d;
  logic [IDX_W-1:0]        gnt_d;

  // Scan last+1, last+2, ... so the most recent winner is considered last.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_MST-1:0] req,
                                               input logic [IDX_W-1:0]   last);
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] cand;
    pick = last;
    for (int i = NUM_MST; i >= 1; i--) begin
      cand = IDX_W'((int'(last) + i) % NUM_MST);
      if (req[cand]) begin
        pick = cand;
      end else begin
        pick = pick;
      end
    end
    return pick;
  endfunction

  function automatic logic [NUM_MST-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_MST-1:0] v;
    v      = {NUM_MST{1'b0}};
    v[idx] = 1'b1;
    return v;
  endfunction

  // Next grant candidate from the current request vector.
  always_comb begin
    any_req_d = |m_req;
    gnt_d     = rr_pick(m_req, last_gnt_q);
  end

  // Transaction sequencer; all bus and requester outputs are registered here.
  always_ff @(posedge reg_clk) begin
    if (reg_rst) begin
      state_q    <= IDLE;
      last_gnt_q <= IDX_W'(NUM_MST - 1);
      wr_q       <= 1'b0;
      m_ack_q    <= {NUM_MST{1'b0}};
      m_rdat_q   <= 32'h0000_0000;
      busy_q     <= 1'b0;
      reg_wr_q   <= 1'b0;
      reg_rd_q   <= 1'b0;
      reg_we_q   <= 4'b0000;
      reg_addr_q <= {ADDR_WIDTH{1'b0}};
      reg_wdat_q <= 32'h0000_0000;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req_d) begin
            last_gnt_q <= gnt_d;
            wr_q       <= m_wr[gnt_d];
            reg_addr_q <= m_addr[gnt_d*ADDR_WIDTH +: ADDR_WIDTH];
            reg_wdat_q <= m_wdat[gnt_d*32 +: 32];
            reg_we_q   <= m_wr[gnt_d] ? m_we[gnt_d*4 +: 4] : 4'b0000;
            reg_wr_q   <= m_wr[gnt_d];
            reg_rd_q   <= ~m_wr[gnt_d];
            busy_q     <= 1'b1;
            state_q    <= ISSUE;
          end else begin
            state_q    <= IDLE;
          end
        end
        ISSUE: begin
          reg_wr_q <= 1'b0;
          reg_rd_q <= 1'b0;
          reg_we_q <= 4'b0000;
          if (wr_q) begin
            m_ack_q <= onehot(last_gnt_q);
            state_q <= DONE;
          end else begin
            state_q <= RDWAIT;
          end
        end
        RDWAIT: begin
          // Slave returns read data one cycle after its strobe.
          m_rdat_q <= reg_rdat;
          m_ack_q  <= onehot(last_gnt_q);
          state_q  <= DONE;
        end
        DONE: begin
          m_ack_q <= {NUM_MST{1'b0}};
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          m_ack_q  <= {NUM_MST{1'b0}};
          busy_q   <= 1'b0;
          reg_wr_q <= 1'b0;
          reg_rd_q <= 1'b0;
          reg_we_q <= 4'b0000;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign m_ack    = m_ack_q;
  assign m_rdat   = m_rdat_q;
  assign busy     = busy_q;
  assign reg_wr   = reg_wr_q;
  assign reg_rd   = reg_rd_q;
  assign reg_we   = reg_we_q;
  assign reg_addr = reg_addr_q;
  assign reg_wdat = reg_wdat_q;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Scoreboard bench for reg_bus_arbiter: a transaction-level model predicts grants,
// bus strobes and acks; a negedge monitor pops and compares what the DUT shows.
module tb_reg_bus_arbiter;

  localparam int NM = 3;
  localparam int AW = 24;

  logic              clk = 1'b0;
  logic              reg_rst = 1'b1;
  logic [NM-1:0]     m_req = '0;
  logic [NM-1:0]     m_wr = '0;
  logic [NM*AW-1:0]  m_addr = '0;
  logic [NM*4-1:0]   m_we = '0;
  logic [NM*32-1:0]  m_wdat = '0;
  logic [NM-1:0]     m_ack;
  logic [31:0]       m_rdat;
  logic              busy;
  logic              reg_wr;
  logic              reg_rd;
  logic [3:0]        reg_we;
  logic [AW-1:0]     reg_addr;
  logic [31:0]       reg_wdat;
  logic [31:0]       reg_rdat = 32'h0;

  reg_bus_arbiter #(.NUM_MST(NM), .ADDR_WIDTH(AW)) dut (
    .reg_clk (clk),     .reg_rst (reg_rst),
    .m_req   (m_req),   .m_wr    (m_wr),    .m_addr (m_addr),
    .m_we    (m_we),    .m_wdat  (m_wdat),  .m_ack  (m_ack),
    .m_rdat  (m_rdat),  .busy    (busy),    .reg_wr (reg_wr),
    .reg_rd  (reg_rd),  .reg_we  (reg_we),  .reg_addr (reg_addr),
    .reg_wdat(reg_wdat), .reg_rdat(reg_rdat)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct { int cyc; bit wr; logic [AW-1:0] addr; logic [3:0] we; logic [31:0] wdat; } bus_t;
  typedef struct { int cyc; int idx; logic [31:0] rdat; } ack_t;
  bus_t exp_bus[$];
  ack_t exp_ack[$];

  // reference model state
  logic [31:0] exp_mem [4] = '{default: 32'h0};
  logic [31:0] last_rdat = 32'h0;
  int last_gnt = NM - 1;
  int next_arb = 0;
  int busy_from = 1;
  int busy_to = 0;

  // requester state
  bit [NM-1:0] pend = '0;
  bit [NM-1:0] granted = '0;
  bit [NM-1:0] hold_rd = '0;
  int rel [NM];
  int prob = 0;
  bit rnd_mode = 1'b0;
  bit mon_en = 1'b0;

  logic [AW-1:0] addr_tab [8] = '{24'h0, 24'h4, 24'h8, 24'h10, 24'h18, 24'h20, 24'h1C, 24'hFFFFF8};

  // slave: four word registers at 0x0, 0x8, 0x10, 0x18; everything else reads 0
  logic [31:0] slv_mem [4] = '{default: 32'h0};

  function automatic bit mapped(input logic [AW-1:0] a);
    return (a[2:0] == 3'b000) && (a < 24'h20);
  endfunction

  function automatic int slot(input logic [AW-1:0] a);
    return int'(a[4:3]);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [NM-1:0] onehot(input int idx);
    logic [NM-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  always @(posedge clk) begin
    if (reg_wr && mapped(reg_addr)) slv_mem[slot(reg_addr)] <= merge(slv_mem[slot(reg_addr)], reg_wdat, reg_we);
    reg_rdat <= (reg_rd && mapped(reg_addr)) ? slv_mem[slot(reg_addr)] : 32'h0;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic post(input int i, input bit wr, input logic [AW-1:0] a, input logic [3:0] be, input logic [31:0] wd);
    pend[i] = 1'b1;
    granted[i] = 1'b0;
    m_req[i] = 1'b1;
    m_wr[i] = wr;
    m_addr[i*AW +: AW] = a;
    m_we[i*4 +: 4] = be;
    m_wdat[i*32 +: 32] = wd;
  endtask

  // Transaction-level prediction for the current cycle's inputs.
  task automatic model_cycle();
    int j;
    int ci;
    int lat;
    bit wr;
    logic [AW-1:0] a;
    logic [3:0] be;
    logic [31:0] wd;
    if (reg_rst) begin
      while (exp_bus.size() > 0 && exp_bus[$].cyc > cyc) void'(exp_bus.pop_back());
      while (exp_ack.size() > 0 && exp_ack[$].cyc > cyc) void'(exp_ack.pop_back());
      if (busy_to > cyc) busy_to = cyc;
      next_arb = cyc + 1;
      last_gnt = NM - 1;
      last_rdat = 32'h0;
      pend = '0;
      granted = '0;
      m_req = '0;
    end else if (cyc >= next_arb && m_req != '0) begin
      j = -1;
      for (int off = 1; off <= NM; off++) begin
        ci = (last_gnt + off) % NM;
        if (j < 0 && m_req[ci]) j = ci;
      end
      wr = m_wr[j];
      a = m_addr[j*AW +: AW];
      be = m_we[j*4 +: 4];
      wd = m_wdat[j*32 +: 32];
      lat = wr ? 2 : 3;
      if (wr) begin
        if (mapped(a)) exp_mem[slot(a)] = merge(exp_mem[slot(a)], wd, be);
      end else begin
        last_rdat = mapped(a) ? exp_mem[slot(a)] : 32'h0;
      end
      exp_bus.push_back('{cyc: cyc + 1, wr: wr, addr: a, we: (wr ? be : 4'h0), wdat: wd});
      exp_ack.push_back('{cyc: cyc + lat, idx: j, rdat: last_rdat});
      busy_from = cyc + 1;
      busy_to = cyc + lat;
      next_arb = cyc + lat + 1;
      last_gnt = j;
      granted[j] = 1'b1;
      rel[j] = cyc + lat;
    end
  endtask

  task automatic step();
    model_cycle();
    @(posedge clk);
    #1;
    for (int i = 0; i < NM; i++) begin
      if (pend[i] && granted[i] && cyc >= rel[i]) begin
        pend[i] = 1'b0;
        granted[i] = 1'b0;
        m_req[i] = 1'b0;
      end
      if (pend[i] && granted[i] && rnd_mode) begin
        if ($urandom_range(3) == 0) begin
          m_wr[i] = ~m_wr[i];
          m_addr[i*AW +: AW] = AW'($urandom);
          m_we[i*4 +: 4] = 4'($urandom);
          m_wdat[i*32 +: 32] = $urandom;
        end
        if ($urandom_range(15) == 0) m_req[i] = 1'b0;
      end
      if (!pend[i]) begin
        if (hold_rd[i]) post(i, 1'b0, addr_tab[$urandom_range(7)], 4'($urandom), $urandom);
        else if (int'($urandom_range(99)) < prob)
          post(i, 1'($urandom_range(1)), addr_tab[$urandom_range(7)], 4'($urandom), $urandom);
      end
    end
  endtask

  task automatic wait_quiet(input int budget);
    int n;
    n = 0;
    while ((pend != '0 || exp_ack.size() != 0 || exp_bus.size() != 0) && n < budget) begin
      step();
      n++;
    end
    chk("drain_left", 64'(exp_ack.size() + exp_bus.size()), 64'd0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_reg_wr"}, 64'(reg_wr), 64'd0);
    chk({tag, "_reg_rd"}, 64'(reg_rd), 64'd0);
    chk({tag, "_reg_we"}, 64'(reg_we), 64'd0);
    chk({tag, "_reg_addr"}, 64'(reg_addr), 64'd0);
    chk({tag, "_reg_wdat"}, 64'(reg_wdat), 64'd0);
    chk({tag, "_m_ack"}, 64'(m_ack), 64'd0);
    chk({tag, "_m_rdat"}, 64'(m_rdat), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  // Monitor: compares DUT outputs against the queued expectations.
  initial begin
    bus_t b;
    ack_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("busy", 64'(busy), 64'(cyc >= busy_from && cyc <= busy_to));
        if (reg_wr || reg_rd) begin
          if (exp_bus.size() == 0) chk("bus_strobe_unexpected", 64'({reg_wr, reg_rd}), 64'd0);
          else begin
            b = exp_bus.pop_front();
            chk("bus_cyc", 64'(cyc), 64'(b.cyc));
            chk("bus_strobe", 64'({reg_wr, reg_rd}), b.wr ? 64'd2 : 64'd1);
            chk("bus_addr", 64'(reg_addr), 64'(b.addr));
            chk("bus_we", 64'(reg_we), 64'(b.we));
            chk("bus_wdat", 64'(reg_wdat), 64'(b.wdat));
          end
        end else begin
          chk("we_idle", 64'(reg_we), 64'd0);
          if (exp_bus.size() > 0 && exp_bus[0].cyc <= cyc) begin
            b = exp_bus.pop_front();
            chk("bus_strobe_missing", 64'({reg_wr, reg_rd}), b.wr ? 64'd2 : 64'd1);
          end
        end
        if (m_ack != '0) begin
          if (exp_ack.size() == 0) chk("ack_unexpected", 64'(m_ack), 64'd0);
          else begin
            e = exp_ack.pop_front();
            chk("ack_cyc", 64'(cyc), 64'(e.cyc));
            chk("ack_idx", 64'(m_ack), 64'(onehot(e.idx)));
            chk("ack_rdat", 64'(m_rdat), 64'(e.rdat));
          end
        end else if (exp_ack.size() > 0 && exp_ack[0].cyc <= cyc) begin
          e = exp_ack.pop_front();
          chk("ack_missing", 64'(m_ack), 64'(onehot(e.idx)));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reg_rst = 1'b1;
    repeat (3) step();
    check_zero("reset");
    reg_rst = 1'b0;
    mon_en = 1'b1;

    // single write then read-back from another requester
    post(0, 1'b1, 24'h0, 4'b0011, 32'h0000_0A5E);
    wait_quiet(20);
    post(1, 1'b0, 24'h0, 4'b1111, 32'h1234_5678);
    wait_quiet(20);
    // unmapped read
    post(0, 1'b0, 24'h4, 4'b0000, 32'h0);
    wait_quiet(20);

    // contention: two requesters keep reading
    hold_rd[0] = 1'b1;
    hold_rd[1] = 1'b1;
    repeat (30) step();
    hold_rd = '0;
    wait_quiet(40);

    // reset during RDWAIT: no ack, all outputs cleared, round robin restarts
    post(0, 1'b0, 24'h0, 4'b0000, 32'h0);
    step();
    step();
    reg_rst = 1'b1;
    step();
    reg_rst = 1'b0;
    check_zero("midrst");
    post(1, 1'b0, 24'h8, 4'b0000, 32'h0);
    post(0, 1'b0, 24'h0, 4'b0000, 32'h0);
    wait_quiet(40);

    // wrap with last grant at NM-1, writes between reads
    post(2, 1'b1, 24'h10, 4'b1111, 32'hCAFE_F00D);
    wait_quiet(20);
    post(1, 1'b1, 24'h18, 4'b1100, 32'hA5A5_0000);
    post(2, 1'b1, 24'h8, 4'b0101, 32'h00FF_00FF);
    step();
    post(0, 1'b0, 24'h10, 4'b0000, 32'h0);
    wait_quiet(40);

    // randomized traffic with post-grant input scrambling and early m_req drops
    rnd_mode = 1'b1;
    prob = 30;
    repeat (3000) step();
    prob = 0;
    rnd_mode = 1'b0;
    wait_quiet(200);
    chk("pend_left", 64'(pend), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
